// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO write path: bandwidth mode encoding and parity.
// Pure declarations; no latency, no backpressure.
package fifo_pkg;

  typedef enum logic [1:0] {
    BW_000 = 2'b00,
    BW_050 = 2'b01,
    BW_100 = 2'b10
  } grant_in_e;

  localparam int PARITY_MAX_W = 64;

  // Zero-extension leaves the parity unchanged, so any word up to 64 bits can be passed in.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
    return ^d;
  endfunction

  // Encoding 2'b11 is reserved and decodes like BW_000.
  function automatic logic bw_allows(input logic [1:0] mode, input logic slot);
    logic ok;
    case (mode)
      BW_100:  ok = 1'b1;
      BW_050:  ok = ~slot;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side req/gnt bundle plus the FIFO write port of the write arbiter.
// Wires only; gnt is same-cycle, FIFO write signals are registered by the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8
);
  logic [N_REQ-1:0]            req;
  logic [N_REQ*DATA_WIDTH-1:0] data_in;
  logic [N_REQ-1:0]            gnt;
  logic [1:0]                  bw_mode;
  logic                        fifo_afull;
  logic                        fifo_wr_en;
  logic [DATA_WIDTH-1:0]       fifo_data;
  logic                        fifo_parity;

  modport master (
    output req, data_in, bw_mode, fifo_afull,
    input  gnt, fifo_wr_en, fifo_data, fifo_parity
  );

  modport slave (
    input  req, data_in, bw_mode, fifo_afull,
    output gnt, fifo_wr_en, fifo_data, fifo_parity
  );
endinterface

// File: rtl/fifo_rr_pick.sv
// Rotate-priority selector: first requester after last_ptr wins; purely combinational.
// Zero latency; en low (afull, throttle, reset) suppresses every grant.
module fifo_rr_pick #(
  parameter int N_REQ = 4,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    last_ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [PW-1:0]    winner,
  output logic             valid
);

  int idx;

  always_comb begin
    gnt    = '0;
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    if (en) begin
      for (int k = 1; k <= N_REQ; k++) begin
        idx = (int'(last_ptr) + k) % N_REQ;
        if (!valid && req[idx]) begin
          valid     = 1'b1;
          winner    = PW'(idx);
          gnt[idx]  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, bandwidth-throttled arbiter for the parity-protected FIFO write port.
// gnt is same-cycle, the FIFO write lands 1 cycle later; no grant while fifo_afull or throttled.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8
) (
  input logic              clk,
  input logic              rst_n,
  fifo_wr_arbiter_if.slave bus
);

  localparam int PW = $clog2(N_REQ);

  logic [PW-1:0]         last_ptr;
  logic [PW-1:0]         winner;
  logic                  slot;
  logic                  pick_en;
  logic                  pick_vld;
  logic [N_REQ-1:0]      pick_gnt;
  logic [DATA_WIDTH-1:0] win_dat;
  logic                  wr_en_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  parity_q;

  // rst_n gates the grant combinationally so nothing is accepted during reset.
  assign pick_en = rst_n && !bus.fifo_afull && bw_allows(bus.bw_mode, slot);

  fifo_rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .req      (bus.req),
    .last_ptr (last_ptr),
    .en       (pick_en),
    .gnt      (pick_gnt),
    .winner   (winner),
    .valid    (pick_vld)
  );

  always_comb begin
    win_dat = bus.data_in[winner*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_ptr <= PW'(N_REQ - 1);
      slot     <= 1'b0;
      wr_en_q  <= 1'b0;
      data_q   <= '0;
      parity_q <= 1'b0;
    end else begin
      slot    <= ~slot;
      wr_en_q <= pick_vld;
      if (pick_vld) begin
        last_ptr <= winner;
        data_q   <= win_dat;
        parity_q <= even_parity(PARITY_MAX_W'(win_dat));
      end
    end
  end

  assign bus.gnt         = pick_gnt;
  assign bus.fifo_wr_en  = wr_en_q;
  assign bus.fifo_data   = data_q;
  assign bus.fifo_parity = parity_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: reference model predicts grants and FIFO writes.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  typedef enum logic [1:0] {
    M_BW_000 = 2'b00,
    M_BW_050 = 2'b01,
    M_BW_100 = 2'b10
  } tb_bw_e;

  typedef struct {
    logic [DW-1:0] d;
    logic          p;
  } wr_t;

  logic clk;
  logic rst_n;

  fifo_wr_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus ();

  fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int  n_chk  = 0;
  int  n_fail = 0;
  int  m_ptr  = N - 1;
  bit  m_slot = 1'b0;
  bit  mon_en = 1'b0;
  bit  rst_chk = 1'b0;
  wr_t exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: evaluated once per cycle between edges, when inputs are stable.
  always @(negedge clk) begin
    logic [N-1:0] eg;
    int  w;
    bit  ok;
    wr_t e;
    mon_en = 1'b1;
    eg = '0;
    w  = -1;
    ok = (rst_n === 1'b1) && (bus.fifo_afull === 1'b0) &&
         ((bus.bw_mode == M_BW_100) || (bus.bw_mode == M_BW_050 && !m_slot));
    if (ok) begin
      for (int k = 1; k <= N; k++) begin
        if (w < 0 && bus.req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
    end
    if (w >= 0) eg[w] = 1'b1;
    n_chk++;
    if (bus.gnt !== eg) begin
      n_fail++;
      $display("FAIL gnt t=%0t got=%b want=%b", $time, bus.gnt, eg);
    end
    if (rst_n !== 1'b1) begin
      m_ptr  = N - 1;
      m_slot = 1'b0;
      rst_chk = 1'b1;
      exp_q.delete();
    end else begin
      m_slot = !m_slot;
      if (w >= 0) begin
        m_ptr = w;
        e.d = bus.data_in[w*DW +: DW];
        e.p = ($countones(e.d) % 2) == 1;
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: pops one expected write whenever the DUT strobes the FIFO.
  always @(posedge clk) begin
    wr_t e;
    #2;
    if (mon_en) begin
      if (rst_chk) begin
        rst_chk = 1'b0;
        n_chk++;
        if (bus.fifo_wr_en !== 1'b0 || bus.fifo_data !== '0 || bus.fifo_parity !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_out got wr=%b d=%h p=%b want wr=0 d=00 p=0",
                   bus.fifo_wr_en, bus.fifo_data, bus.fifo_parity);
        end
      end else if (bus.fifo_wr_en === 1'b1) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL wr_unexpected t=%0t got wr=1 d=%h want no write", $time, bus.fifo_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.fifo_data !== e.d || bus.fifo_parity !== e.p) begin
            n_fail++;
            $display("FAIL wr_data t=%0t got d=%h p=%b want d=%h p=%b",
                     $time, bus.fifo_data, bus.fifo_parity, e.d, e.p);
          end
        end
      end else if (bus.fifo_wr_en !== 1'b0) begin
        n_chk++;
        n_fail++;
        $display("FAIL wr_en_x t=%0t got=%b want 0/1", $time, bus.fifo_wr_en);
      end
    end
  end

  task automatic step(input logic rn, input logic [N-1:0] r, input logic [1:0] m,
                      input logic af, input logic [N*DW-1:0] dat,
                      input logic [N-1:0] exp, input bit chk);
    @(posedge clk);
    #1;
    rst_n          = rn;
    bus.req        = r;
    bus.bw_mode    = m;
    bus.fifo_afull = af;
    bus.data_in    = dat;
    @(negedge clk);
    if (chk) begin
      n_chk++;
      if (bus.gnt !== exp) begin
        n_fail++;
        $display("FAIL dir_gnt t=%0t got=%b want=%b", $time, bus.gnt, exp);
      end
    end
  endtask

  initial begin
    logic [N-1:0] dir[8];
    rst_n          = 1'b0;
    bus.req        = '0;
    bus.bw_mode    = M_BW_100;
    bus.fifo_afull = 1'b0;
    bus.data_in    = '0;

    // Reset, then full rotation.
    step(0, 4'b1111, M_BW_100, 0, 32'h44332211, 4'b0000, 1);
    step(0, 4'b1111, M_BW_100, 0, 32'h44332211, 4'b0000, 1);
    dir = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 5; i++) step(1, 4'b1111, M_BW_100, 0, 32'h44332211, dir[i], 1);

    // Half-rate throttle after a fresh reset.
    step(0, 4'b0001, M_BW_050, 0, 32'h00000007, 4'b0000, 1);
    for (int i = 0; i < 6; i++)
      step(1, 4'b0001, M_BW_050, 0, 32'h00000007, (i % 2 == 0) ? 4'b0001 : 4'b0000, 1);

    // Almost-full stall mid-stream; rotation resumes without skip or repeat.
    dir = '{4'b0010, 4'b0100, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0010};
    for (int i = 0; i < 8; i++)
      step(1, 4'b0110, M_BW_100, (i >= 3 && i < 6), 32'hA5C3_3C5A, dir[i], 1);

    // Zero-bandwidth and reserved modes, then same-cycle switch to full rate.
    for (int i = 0; i < 3; i++) step(1, 4'b1111, M_BW_000, 0, 32'hDEADBEEF, 4'b0000, 1);
    for (int i = 0; i < 3; i++) step(1, 4'b1111, 2'b11,    0, 32'hDEADBEEF, 4'b0000, 1);
    step(1, 4'b1111, M_BW_100, 0, 32'hDEADBEEF, 4'b0100, 1);

    // One-cycle reset during continuous traffic.
    for (int i = 0; i < 3; i++) step(1, 4'b1111, M_BW_100, 0, 32'h8040_2010, 4'b0000, 0);
    step(0, 4'b1111, M_BW_100, 0, 32'h8040_2010, 4'b0000, 1);
    step(1, 4'b1111, M_BW_100, 0, 32'h8040_2010, 4'b0001, 1);

    // Lone requester 3, then requesters 3 and 0 alternate.
    step(0, 4'b0000, M_BW_100, 0, 32'h0, 4'b0000, 1);
    step(1, 4'b1000, M_BW_100, 0, 32'hF1000001, 4'b1000, 1);
    step(1, 4'b1000, M_BW_100, 0, 32'hF1000001, 4'b1000, 1);
    dir = '{4'b0001, 4'b1000, 4'b0001, 4'b1000, 4'b0001, 4'b1000, 4'b0001, 4'b1000};
    for (int i = 0; i < 4; i++) step(1, 4'b1001, M_BW_100, 0, 32'hF1000001, dir[i], 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 49) != 0), N'($urandom), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 4) == 0), $urandom, 4'b0000, 0);

    for (int i = 0; i < 3; i++) step(1, 4'b0000, M_BW_100, 0, 32'h0, 4'b0000, 1);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending writes want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
